// File: rtl/sensor_sequencer.sv
// -----------------------------------------------------------------------------
// sensor_sequencer
//
// Frame sequencer for the pixel sensor array. It runs the
// erase -> expose -> convert -> read cycle for one frame per START request.
// In continuous mode it chains frames back to back without returning to IDLE.
//
// Parameters
//   PIXEL_ARRAY_HEIGHT : number of rows (width of the one-hot row select)
//   PIXEL_BITS         : ramp resolution, convert lasts 2**PIXEL_BITS cycles
//   ERASE_TIME         : erase phase length in cycles (>= 1)
//   ROW_READ_TIME      : cycles each row stays selected (>= 1)
//   EXPOSE_BITS        : width of expose_time_i
//   FRAME_COUNT_BITS   : width of frame_count_o
//
// Ports
//   clk_i                : clock, all state changes on the rising edge
//   reset_i              : asynchronous active-high reset
//   start_i              : frame request, only looked at in IDLE
//   continuous_i         : 1 = chain the next frame after READ
//   expose_time_i        : exposure length in cycles (0 behaves as 1)
//   busy_o               : high in every state except IDLE
//   pixel_erase_o        : high during ERASE
//   pixel_expose_o       : high during EXPOSE
//   pixel_analog_ramp_o  : ramp-run enable, high during CONVERT
//   pixel_digital_ramp_o : Gray-coded ramp value
//   sensor_row_select_o  : one-hot row select during READ, 0 otherwise
//   new_row_o            : pulse on the first cycle of each selected row
//   frame_finished_o     : one-cycle pulse in the first cycle after READ
//   frame_count_o        : completed frames, wrapping
//
// Every output is either a flop or a decode of flops; nothing depends
// combinationally on the inputs, so a reset clears all outputs at once.
// -----------------------------------------------------------------------------
module sensor_sequencer #(
    parameter int PIXEL_ARRAY_HEIGHT = 2,
    parameter int PIXEL_BITS         = 8,
    parameter int ERASE_TIME         = 5,
    parameter int ROW_READ_TIME      = 5,
    parameter int EXPOSE_BITS        = 8,
    parameter int FRAME_COUNT_BITS   = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic                          continuous_i,
    input  logic [EXPOSE_BITS-1:0]        expose_time_i,
    output logic                          busy_o,
    output logic                          pixel_erase_o,
    output logic                          pixel_expose_o,
    output logic                          pixel_analog_ramp_o,
    output logic [PIXEL_BITS-1:0]         pixel_digital_ramp_o,
    output logic [PIXEL_ARRAY_HEIGHT-1:0] sensor_row_select_o,
    output logic                          new_row_o,
    output logic                          frame_finished_o,
    output logic [FRAME_COUNT_BITS-1:0]   frame_count_o
);

    // -------------------------------------------------------------------------
    // Sizing
    // -------------------------------------------------------------------------
    // The phase counter serves ERASE, EXPOSE and the per-row dwell in READ.
    // CONVERT is timed by the ramp counter itself, so it does not need to fit.
    localparam int EXPOSE_MAX = (1 << EXPOSE_BITS) - 1;
    localparam int PH_MAX_A   = (ERASE_TIME > ROW_READ_TIME) ? ERASE_TIME : ROW_READ_TIME;
    localparam int PH_MAX     = (PH_MAX_A > EXPOSE_MAX) ? PH_MAX_A : EXPOSE_MAX;
    localparam int PH_W       = $clog2(PH_MAX + 1);
    localparam int ROW_W      = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;

    localparam logic [PH_W-1:0]  ERASE_LAST = PH_W'(ERASE_TIME - 1);
    localparam logic [PH_W-1:0]  ROW_LAST   = PH_W'(ROW_READ_TIME - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                      state_q,    state_d;
    logic [PH_W-1:0]             phase_q,    phase_d;
    logic [PIXEL_BITS-1:0]       ramp_q,     ramp_d;
    logic [ROW_W-1:0]            row_q,      row_d;
    logic [EXPOSE_BITS-1:0]      expose_q,   expose_d;
    logic [FRAME_COUNT_BITS-1:0] count_q,    count_d;
    logic                        finished_q, finished_d;

    // Exposure value captured at frame start; zero is promoted to one so the
    // EXPOSE phase always lasts at least a cycle.
    logic [EXPOSE_BITS-1:0] expose_latch;
    logic [EXPOSE_BITS-1:0] expose_last;
    logic [PIXEL_BITS-1:0]  ramp_gray;
    logic [PIXEL_ARRAY_HEIGHT-1:0] row_onehot;

    assign expose_latch = (expose_time_i == '0) ? EXPOSE_BITS'(1) : expose_time_i;
    assign expose_last  = expose_q - EXPOSE_BITS'(1);
    assign ramp_gray    = ramp_q ^ (ramp_q >> 1);

    // One-hot decode of the current row index.
    generate
        for (genvar gi = 0; gi < PIXEL_ARRAY_HEIGHT; gi++) begin : g_row_dec
            assign row_onehot[gi] = (row_q == ROW_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Process 1: state register (FSM state plus its counters)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            ramp_q     <= '0;
            row_q      <= '0;
            expose_q   <= EXPOSE_BITS'(1);
            count_q    <= '0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            ramp_q     <= ramp_d;
            row_q      <= row_d;
            expose_q   <= expose_d;
            count_q    <= count_d;
            finished_q <= finished_d;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state and counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        ramp_d     = ramp_q;
        row_d      = row_q;
        expose_d   = expose_q;
        count_d    = count_q;
        finished_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_ERASE;
                    phase_d  = '0;
                    expose_d = expose_latch;
                end
            end

            ST_ERASE: begin
                if (phase_q == ERASE_LAST) begin
                    state_d = ST_EXPOSE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            ST_EXPOSE: begin
                if (phase_q == PH_W'(expose_last)) begin
                    state_d = ST_CONVERT;
                    phase_d = '0;
                    // Ramp restarts from zero on every CONVERT entry.
                    ramp_d  = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            ST_CONVERT: begin
                // The ramp reaching full scale marks the last CONVERT cycle;
                // it then holds that value until the next CONVERT.
                if (ramp_q == '1) begin
                    state_d = ST_READ;
                    phase_d = '0;
                    row_d   = '0;
                end else begin
                    ramp_d = ramp_q + PIXEL_BITS'(1);
                end
            end

            ST_READ: begin
                if (phase_q == ROW_LAST) begin
                    phase_d = '0;
                    if (row_q == LAST_ROW) begin
                        finished_d = 1'b1;
                        count_d    = count_q + FRAME_COUNT_BITS'(1);
                        if (continuous_i) begin
                            state_d  = ST_ERASE;
                            expose_d = expose_latch;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Process 3: output decode from registered state
    // -------------------------------------------------------------------------
    always_comb begin
        busy_o               = (state_q != ST_IDLE);
        pixel_erase_o        = (state_q == ST_ERASE);
        pixel_expose_o       = (state_q == ST_EXPOSE);
        pixel_analog_ramp_o  = (state_q == ST_CONVERT);
        pixel_digital_ramp_o = ramp_gray;
        sensor_row_select_o  = '0;
        new_row_o            = 1'b0;
        if (state_q == ST_READ) begin
            sensor_row_select_o = row_onehot;
            // Phase counter restarts for every row, so zero marks a new row.
            new_row_o           = (phase_q == '0);
        end
        frame_finished_o     = finished_q;
        frame_count_o        = count_q;
    end

endmodule

// File: tb/tb_sensor_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sensor_sequencer
//
// Directed bench for sensor_sequencer. dut0 uses the default parameters
// (2 rows, 8-bit ramp, erase 5, row time 5); dut1 uses 4 rows, row time 3,
// 3-bit ramp, erase 2 and a 2-bit frame counter for continuous-mode runs.
// -----------------------------------------------------------------------------
module tb_sensor_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // dut0 signals
    logic       start0, cont0;
    logic [7:0] exp0;
    logic       busy0, erase0, expose0, ramp_en0, new_row0, fin0;
    logic [7:0] gray0;
    logic [1:0] sel0;
    logic [7:0] count0;

    // dut1 signals
    logic       start1, cont1;
    logic [3:0] exp1;
    logic       busy1, erase1, expose1, ramp_en1, new_row1, fin1;
    logic [2:0] gray1;
    logic [3:0] sel1;
    logic [1:0] count1;

    int checks = 0;
    int errors = 0;

    sensor_sequencer dut0 (
        .clk_i                (clk),
        .reset_i              (rst),
        .start_i              (start0),
        .continuous_i         (cont0),
        .expose_time_i        (exp0),
        .busy_o               (busy0),
        .pixel_erase_o        (erase0),
        .pixel_expose_o       (expose0),
        .pixel_analog_ramp_o  (ramp_en0),
        .pixel_digital_ramp_o (gray0),
        .sensor_row_select_o  (sel0),
        .new_row_o            (new_row0),
        .frame_finished_o     (fin0),
        .frame_count_o        (count0)
    );

    sensor_sequencer #(
        .PIXEL_ARRAY_HEIGHT (4),
        .PIXEL_BITS         (3),
        .ERASE_TIME         (2),
        .ROW_READ_TIME      (3),
        .EXPOSE_BITS        (4),
        .FRAME_COUNT_BITS   (2)
    ) dut1 (
        .clk_i                (clk),
        .reset_i              (rst),
        .start_i              (start1),
        .continuous_i         (cont1),
        .expose_time_i        (exp1),
        .busy_o               (busy1),
        .pixel_erase_o        (erase1),
        .pixel_expose_o       (expose1),
        .pixel_analog_ramp_o  (ramp_en1),
        .pixel_digital_ramp_o (gray1),
        .sensor_row_select_o  (sel1),
        .new_row_o            (new_row1),
        .frame_finished_o     (fin1),
        .frame_count_o        (count1)
    );

    function automatic logic [7:0] vec0();
        return {busy0, erase0, expose0, ramp_en0, sel0, new_row0, fin0};
    endfunction

    function automatic logic [9:0] vec1();
        return {busy1, erase1, expose1, ramp_en1, sel1, new_row1, fin1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One single-shot frame on dut0. eff is the exposure the frame must use;
    // mid_val is driven onto expose_time during EXPOSE; hold_start raises
    // START in the last READ cycle and leaves it high on return.
    task automatic run0(input logic [7:0] exp_in, input int eff, input logic [7:0] mid_val,
                        input bit hold_start, input int fc);
        int         total;
        int         j;
        int         r;
        logic [7:0] e;
        logic [7:0] g;
        logic [7:0] prev_g;
        total  = 5 + eff + 256 + 10;
        prev_g = '0;
        exp0   = exp_in;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < total; i++) begin
            if (i < 5) begin
                e = 8'b1100_0000;
            end else if (i < 5 + eff) begin
                e = 8'b1010_0000;
            end else if (i < 5 + eff + 256) begin
                e = 8'b1001_0000;
            end else begin
                r = i - (5 + eff + 256);
                e = {4'b1000, 2'(1 << (r / 5)), (r % 5 == 0), 1'b0};
            end
            chk($sformatf("f0_cycle%0d", i), 32'(vec0()), 32'(e));
            if (i >= 5 + eff && i < 5 + eff + 256) begin
                j = i - (5 + eff);
                g = 8'(j ^ (j >> 1));
                chk($sformatf("f0_gray%0d", j), 32'(gray0), 32'(g));
                if (j > 0)
                    chk($sformatf("f0_gray_step%0d", j), 32'($countones(gray0 ^ prev_g)), 32'd1);
                prev_g = gray0;
            end
            if (i == 6 && eff > 1)
                exp0 = mid_val;
            if (i == total - 1 && hold_start)
                start0 = 1'b1;
            tick();
        end
        chk("f0_finish", 32'(vec0()), 32'h01);
        chk("f0_count", 32'(count0), 32'(fc));
        chk("f0_gray_hold", 32'(gray0), 32'h80);
        $display("dut0 frame done exposure=%0d count=%0d", eff, count0);
        if (!hold_start) begin
            tick();
            chk("f0_idle_after", 32'(vec0()), 32'h00);
            chk("f0_count_hold", 32'(count0), 32'(fc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int         eff;
        int         total;
        int         r;
        logic       eb, xb, rb, nb, fb;
        logic [3:0] sb;

        rst    = 1'b1;
        start0 = 1'b0;
        cont0  = 1'b0;
        exp0   = 8'd0;
        start1 = 1'b0;
        cont1  = 1'b0;
        exp1   = 4'd0;

        // Reset state
        tick();
        tick();
        chk("rst_vec0", 32'(vec0()), 32'h0);
        chk("rst_count0", 32'(count0), 32'h0);
        chk("rst_gray0", 32'(gray0), 32'h0);
        chk("rst_vec1", 32'(vec1()), 32'h0);
        chk("rst_count1", 32'(count1), 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_no_start", 32'(vec0()), 32'h0);

        // Default frame, exposure 3
        run0(8'd3, 3, 8'd3, 1'b0, 1);
        // Exposure 0 behaves as 1
        run0(8'd0, 1, 8'd0, 1'b0, 2);
        // Exposure changed 3 -> 7 mid-EXPOSE; START held across the last READ edge
        run0(8'd3, 3, 8'd7, 1'b1, 3);
        tick();
        start0 = 1'b0;
        chk("restart_after_idle", 32'(vec0()), 32'hC0);
        chk("restart_fin_clear", 32'(fin0), 32'h0);

        // Asynchronous reset in the middle of CONVERT
        repeat (20) tick();
        chk("pre_reset_convert", 32'(vec0()), 32'h90);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_vec0", 32'(vec0()), 32'h0);
        chk("async_rst_gray0", 32'(gray0), 32'h0);
        chk("async_rst_count0", 32'(count0), 32'h0);
        $display("dut0 reset mid-convert applied");
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(vec0()), 32'h0);

        // Continuous mode on dut1: 5 frames, exposure 2 then relatched as 4
        cont1  = 1'b1;
        exp1   = 4'd2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int f = 0; f < 5; f++) begin
            eff   = (f <= 1) ? 2 : 4;
            total = 2 + eff + 8 + 12;
            for (int i = 0; i < total; i++) begin
                eb = (i < 2);
                xb = (i >= 2 && i < 2 + eff);
                rb = (i >= 2 + eff && i < 2 + eff + 8);
                sb = 4'b0000;
                nb = 1'b0;
                if (i >= 2 + eff + 8) begin
                    r  = i - (2 + eff + 8);
                    sb = 4'(1 << (r / 3));
                    nb = (r % 3 == 0);
                end
                fb = (i == 0 && f > 0);
                chk($sformatf("f1_frame%0d_cycle%0d", f, i), 32'(vec1()),
                    32'({1'b1, eb, xb, rb, sb, nb, fb}));
                if (i == 0 && f > 0) begin
                    chk($sformatf("f1_count_frame%0d", f), 32'(count1), 32'(f % 4));
                    $display("dut1 continuous frame %0d finished count=%0d", f, count1);
                end
                if (f == 1 && i == 10)
                    exp1 = 4'd4;
                start1 = (i == 4 || i == 15);
                if (f == 4 && i == total - 1)
                    cont1 = 1'b0;
                tick();
            end
        end
        start1 = 1'b0;
        chk("f1_last_finish", 32'(vec1()), 32'h001);
        chk("f1_last_count", 32'(count1), 32'd1);
        $display("dut1 continuous frame 5 finished count=%0d", count1);
        tick();
        chk("f1_idle_after", 32'(vec1()), 32'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_sequencer.md
# sensor_sequencer

Parametrised frame sequencer for the pixel sensor array, successor to the fixed-timing sensor state block. It drives the erase → expose → convert → read cycle for a configurable array height, ramp resolution and row-read time. It adds a START handshake, a runtime-programmable exposure time, single-shot or continuous mode, a BUSY flag and a frame counter. It sits between the top-level controller and the pixel array / row readout logic.

## Interface
Parameters:
- PIXEL_ARRAY_HEIGHT, 2, number of rows; width of the one-hot row select.
- PIXEL_BITS, 8, ramp resolution; the convert phase lasts 2**PIXEL_BITS cycles.
- ERASE_TIME, 5, erase phase length in cycles (≥1).
- ROW_READ_TIME, 5, cycles each row is selected (≥1).
- EXPOSE_BITS, 8, width of EXPOSE_TIME.
- FRAME_COUNT_BITS, 8, width of FRAME_COUNT.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  frame request; sampled only in IDLE.
- CONTINUOUS  in  1  1 = restart automatically after READ; 0 = return to IDLE.
- EXPOSE_TIME  in  EXPOSE_BITS  exposure length in cycles; 0 is treated as 1.
- BUSY  out  1  high in every state except IDLE.
- PIXEL_ERASE  out  1  high during ERASE.
- PIXEL_EXPOSE  out  1  high during EXPOSE.
- PIXEL_ANALOG_RAMP  out  1  ramp-run enable, high during CONVERT.
- PIXEL_DIGITAL_RAMP  out  PIXEL_BITS  Gray-coded ramp value.
- SENSOR_ROW_SELECT  out  PIXEL_ARRAY_HEIGHT  one-hot row select during READ; 0 otherwise.
- NEW_ROW  out  1  one-cycle pulse on the first cycle of each selected row.
- FRAME_FINISHED  out  1  one-cycle pulse when a frame completes.
- FRAME_COUNT  out  FRAME_COUNT_BITS  completed frames, modulo 2**FRAME_COUNT_BITS.

## Operation
- State register: IDLE, ERASE, EXPOSE, CONVERT, READ. One phase counter, sized for the largest phase length. One binary ramp counter of PIXEL_BITS bits. One row index counter.
- All outputs are registered or decoded from registered state only. No output is combinational from CLK.
- IDLE → ERASE when START=1. On the same edge: EXPOSE_TIME is latched (0 is latched as 1), and the phase counter is cleared.
- ERASE → EXPOSE after ERASE_TIME cycles.
- EXPOSE → CONVERT after the latched exposure count of cycles.
- CONVERT → READ after 2**PIXEL_BITS cycles.
- CONVERT ramp: the binary ramp counter runs 0 … 2**PIXEL_BITS−1, one step per cycle. PIXEL_DIGITAL_RAMP = bin ^ (bin>>1). It holds its last value after CONVERT and clears to 0 on entry to the next CONVERT.
- READ lasts ROW_READ_TIME*PIXEL_ARRAY_HEIGHT cycles. Row i is selected for cycles i*ROW_READ_TIME … (i+1)*ROW_READ_TIME−1 of READ, starting at row 0 (LSB). NEW_ROW is high on cycle 0 of each row.
- End of READ:
  - FRAME_FINISHED pulses for 1 cycle.
  - FRAME_COUNT increments, wrapping to 0.
  - If CONTINUOUS=1 at the last READ cycle: go to ERASE and re-latch EXPOSE_TIME.
  - Else: go to IDLE.
- START outside IDLE is ignored, and no request is queued. EXPOSE_TIME changes mid-frame have no effect until the next latch.

## Timing
- Reset values: state IDLE, all outputs 0 (BUSY, PIXEL_*, SENSOR_ROW_SELECT, NEW_ROW, FRAME_FINISHED, FRAME_COUNT). Reset is asynchronous and effective at any point mid-frame. No pulse is emitted on reset.
- START latency: if START is high at edge k in IDLE, BUSY and PIXEL_ERASE are high from edge k onward.
- Frame length: ERASE_TIME + max(EXPOSE_TIME,1) + 2**PIXEL_BITS + ROW_READ_TIME*PIXEL_ARRAY_HEIGHT cycles, with no gap between phases.
- Phase outputs: exactly one of PIXEL_ERASE, PIXEL_EXPOSE, PIXEL_ANALOG_RAMP, or SENSOR_ROW_SELECT≠0 is active in any busy cycle.
- FRAME_FINISHED is asserted in the first cycle after READ:
  - single-shot: concurrent with BUSY=0;
  - continuous: concurrent with PIXEL_ERASE=1.
- FRAME_COUNT updates in that same cycle.
- In continuous mode BUSY never drops between frames.
- START asserted in the same cycle that FRAME_FINISHED returns to IDLE is not sampled. START sampled on the following edge starts the next frame.

## Test plan
- Reset mid-CONVERT → all outputs 0 immediately, without waiting for a clock edge; state IDLE; FRAME_COUNT 0.
- Defaults, EXPOSE_TIME=3, one START pulse, CONTINUOUS=0 → ERASE 5, EXPOSE 3, CONVERT 256, READ 10 cycles; BUSY high for exactly 274 cycles; then one FRAME_FINISHED pulse with FRAME_COUNT=1.
- CONVERT sweep with PIXEL_BITS=8 → PIXEL_DIGITAL_RAMP steps through Gray codes 0x00, 0x01, 0x03, 0x02 … 0x80. Every consecutive pair differs by exactly one bit.
- READ with PIXEL_ARRAY_HEIGHT=4, ROW_READ_TIME=3 → SENSOR_ROW_SELECT = 0001, 0010, 0100, 1000, each for 3 cycles; NEW_ROW pulses 4 times, 3 cycles apart.
- EXPOSE_TIME=0 → EXPOSE lasts 1 cycle.
- EXPOSE_TIME changed from 3 to 7 during EXPOSE → the current frame still uses 3.
- CONTINUOUS=1 with FRAME_COUNT_BITS=2, run 5 frames → BUSY stays high; FRAME_COUNT reads 1, 2, 3, 0, 1. START pulses during a frame do not alter timing.
